alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001: CLK  input  1  single system clock; all state updates on rising edge.
REQ-002: RESET  input  1  synchronous, active-low reset; sampled on rising CLK.
REQ-003: INSTR_VALID  input  1  instruction presented this cycle.
REQ-004: INSTR_READY  output  1  block can accept an instruction this cycle.
REQ-005: OPCODE  input  3  000 LOADI, 001 MOV, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 BEQ, 111 reserved.
REQ-006: RD, RS, RT  input  3 each  destination and source register indices.
REQ-007: IMM  input  8  immediate operand for LOADI.
REQ-008: ALU_DATA1, ALU_DATA2  output  8 each  operands driven to the ALU.
REQ-009: ALU_SELECT  output  3  ALU op: 000 forward DATA2, 001 add, 010 and, 011 or.
REQ-010: ALU_RESULT  input  8  ALU result.
REQ-011: ALU_ZERO  input  1  ALU zero flag on the add result.
REQ-012: DONE  output  1  one-cycle pulse at instruction completion.
REQ-013: BRANCH_TAKEN  output  1  valid only while DONE=1.
REQ-014: DBG_ADDR  input  3 / DBG_DATA  output  8  combinational read port of the register file.

Function
REQ-015: The block SHALL contain an 8 x 8-bit register file (R0..R7); R0 is an ordinary writable register.
REQ-016: States SHALL be IDLE, EXEC, WB; INSTR_READY = (state==IDLE) and RESET high.
REQ-017: Accept SHALL occur on a rising edge with INSTR_VALID=1 and INSTR_READY=1:
  - Latch opcode and RD.
  - Read RS/RT values from the register file.
  - Load ALU_DATA1/ALU_DATA2/ALU_SELECT registers.
  - Go to EXEC.
REQ-018: Operand mapping SHALL be:
  - LOADI: DATA2=IMM, SELECT=000.
  - MOV: DATA2=R[RS], SELECT=000.
  - ADD: DATA1=R[RS], DATA2=R[RT], SELECT=001.
  - SUB/BEQ: DATA1=R[RS], DATA2=two's complement of R[RT] (8-bit), SELECT=001.
  - AND: SELECT=010; OR: SELECT=011.
  - Unused DATA1 driven 0x00.
REQ-019: EXEC SHALL last L cycles (L=1 for LOADI/MOV/AND/OR/reserved; L=2 for ADD/SUB/BEQ), counted by an internal counter; the block then goes to WB.
REQ-020: ALU_DATA1/ALU_DATA2/ALU_SELECT SHALL be held constant from accept through the end of WB.
REQ-021: In WB, on the edge leaving WB, R[RD] SHALL be written with ALU_RESULT for opcodes 000-101; BEQ and reserved SHALL write nothing.
REQ-022: DONE SHALL be 1 for exactly the WB cycle; BRANCH_TAKEN SHALL be ALU_ZERO during WB for BEQ, 0 otherwise; WB always returns to IDLE.
REQ-023: DONE SHALL be asserted in cycle L+1 after the accept edge.
REQ-024: Arithmetic SHALL be modulo 256; carry/overflow are discarded.
REQ-025: INSTR_VALID during EXEC/WB SHALL be ignored; the instruction must be held until accepted.
REQ-026: An instruction accepted right after WB SHALL observe the value just written (RAW safe by construction).

Reset
REQ-027: RESET=0 at a rising edge SHALL:
  - Clear all registers R0..R7 to 0x00.
  - Force state IDLE with the counter at 0.
  - Drive ALU_DATA1/ALU_DATA2 to 0x00, ALU_SELECT to 000, DONE and BRANCH_TAKEN to 0.
REQ-028: Reset during EXEC or WB SHALL abort the instruction with no register write and no DONE pulse.

Verification
REQ-029: Reset held 2 cycles -> all DBG_DATA reads 0x00, DONE=0, INSTR_READY=0 during reset, then 1 after release.
REQ-030: LOADI R1,0x05; LOADI R2,0x03; ADD R3,R1,R2 -> R3=0x08; ADD DONE 3 cycles after accept, LOADI DONE 2 cycles after accept.
REQ-031: SUB R4,R2,R1 (0x03-0x05) -> R4=0xFE; LOADI R5,0xFF; LOADI R6,0x01; ADD R7,R5,R6 -> R7=0x00.
REQ-032: BEQ R1,R1 -> BRANCH_TAKEN=1 with DONE; BEQ R1,R2 -> BRANCH_TAKEN=0; no register changes.
REQ-033: ADD accepted, RESET=0 in second EXEC cycle -> DONE never pulses, R[RD]=0x00.
REQ-034: INSTR_VALID held high continuously across 3 instructions -> exactly one accept per IDLE cycle; AND 0xF0&0x3C=0x30 and OR 0xF0|0x0F=0xFF written correctly.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues register-file operands to an external ALU and writes results back
module alu_issue_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [2:0] opcode,
  input  logic [2:0] rd,
  input  logic [2:0] rs,
  input  logic [2:0] rt,
  input  logic [7:0] imm,
  output logic [7:0] alu_data1,
  output logic [7:0] alu_data2,
  output logic [2:0] alu_select,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  output logic       done,
  output logic       branch_taken,
  input  logic [2:0] dbg_addr,
  output logic [7:0] dbg_data
);
  localparam logic [2:0] LOADI = 3'b000, MOV = 3'b001, ADD = 3'b010, SUB = 3'b011;
  localparam logic [2:0] AND_OP = 3'b100, OR_OP = 3'b101, BEQ = 3'b110, RSVD = 3'b111;
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  state_t state;
  logic [7:0] rf [8];
  logic [2:0] op_q, rd_q;
  logic two_q, cnt;
  logic [7:0] a, b, d1, d2;
  logic [2:0] sel;
  logic is_sub, is_add;
  always_comb begin
    a = rf[rs];
    b = rf[rt];
    is_sub = opcode == SUB || opcode == BEQ;
    is_add = opcode == ADD || is_sub;
    d1 = (is_add || opcode == AND_OP || opcode == OR_OP) ? a : 8'h00;
    d2 = opcode == LOADI ? imm : opcode == MOV ? a : is_sub ? ~b + 8'd1 : opcode == RSVD ? 8'h00 : b;
    sel = opcode == AND_OP ? 3'b010 : opcode == OR_OP ? 3'b011 : is_add ? 3'b001 : 3'b000;
  end
  assign instr_ready = state == IDLE && reset;
  assign dbg_data = rf[dbg_addr];
  assign branch_taken = done && op_q == BEQ && alu_zero;
  // Operand registers stay untouched outside accept so they hold through WB
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= 1'b0;
      two_q <= 1'b0;
      op_q <= 3'b000;
      rd_q <= 3'b000;
      alu_data1 <= 8'h00;
      alu_data2 <= 8'h00;
      alu_select <= 3'b000;
      done <= 1'b0;
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
    end else if (state == IDLE) begin
      if (instr_valid) begin
        op_q <= opcode;
        rd_q <= rd;
        two_q <= is_add;
        alu_data1 <= d1;
        alu_data2 <= d2;
        alu_select <= sel;
        cnt <= 1'b0;
        state <= EXEC;
      end
    end else if (state == EXEC) begin
      if (two_q && !cnt) begin
        cnt <= 1'b1;
      end else begin
        cnt <= 1'b0;
        done <= 1'b1;
        state <= WB;
      end
    end else begin
      done <= 1'b0;
      state <= IDLE;
      if (op_q <= OR_OP) rf[rd_q] <= alu_result;
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench with a behavioural ALU and register-file model
module tb_alu_issue_ctrl;
  logic clk = 0, reset = 0, instr_valid = 0, instr_ready;
  logic [2:0] opcode = 0, rd = 0, rs = 0, rt = 0, alu_select, dbg_addr = 0;
  logic [7:0] imm = 0, alu_data1, alu_data2, alu_result, dbg_data;
  logic alu_zero, done, branch_taken;
  int total = 0, bad = 0, acc = 0;
  logic [7:0] m [8];
  typedef struct {
    int lat;
    logic bt;
    logic wr;
    logic [2:0] rd;
    logic [7:0] val;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [2:0] sel;
  } exp_t;
  exp_t sb[$];

  alu_issue_ctrl dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_select(alu_select),
    .alu_result(alu_result), .alu_zero(alu_zero), .done(done), .branch_taken(branch_taken),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = alu_select == 3'b001 ? alu_data1 + alu_data2 :
                 alu_select == 3'b010 ? alu_data1 & alu_data2 :
                 alu_select == 3'b011 ? alu_data1 | alu_data2 : alu_data2;
    alu_zero = 8'(alu_data1 + alu_data2) == 8'h00;
  end

  always @(posedge clk) if (instr_valid && instr_ready) acc++;

  task automatic issue(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s,
                       input logic [2:0] t, input logic [7:0] im, input bit keep);
    exp_t e;
    int k;
    logic [7:0] x, y;
    x = m[s];
    y = m[t];
    e.lat = 2; e.bt = 0; e.wr = 1; e.rd = d; e.d1 = 8'h00; e.d2 = 8'h00; e.sel = 3'b000; e.val = 8'h00;
    case (op)
      3'd0: begin e.val = im; e.d2 = im; end
      3'd1: begin e.val = x; e.d2 = x; end
      3'd2: begin e.lat = 3; e.val = x + y; e.d1 = x; e.d2 = y; e.sel = 3'b001; end
      3'd3: begin e.lat = 3; e.val = x - y; e.d1 = x; e.d2 = 8'h00 - y; e.sel = 3'b001; end
      3'd4: begin e.val = x & y; e.d1 = x; e.d2 = y; e.sel = 3'b010; end
      3'd5: begin e.val = x | y; e.d1 = x; e.d2 = y; e.sel = 3'b011; end
      3'd6: begin e.lat = 3; e.wr = 0; e.bt = x == y; e.d1 = x; e.d2 = 8'h00 - y; e.sel = 3'b001; end
      default: begin e.wr = 0; end
    endcase
    sb.push_back(e);
    k = 0;
    while (!instr_ready && k < 20) begin @(negedge clk); k++; end
    total++;
    if (!instr_ready) begin bad++; $display("FAIL ready_wait: instr_ready=%b want 1", instr_ready); end
    instr_valid = 1; opcode = op; rd = d; rs = s; rt = t; imm = im;
    @(posedge clk);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        total++;
        if ({alu_data1, alu_data2, alu_select} !== {e.d1, e.d2, e.sel}) begin
          bad++;
          $display("FAIL operands op=%0d: got %h/%h/%0d want %h/%h/%0d", op, alu_data1, alu_data2, alu_select, e.d1, e.d2, e.sel);
        end
      end
    end while (!done && k < 10);
    e = sb.pop_front();
    total++;
    if (k !== e.lat || !done) begin bad++; $display("FAIL done_latency op=%0d: got %0d (done=%b) want %0d", op, k, done, e.lat); end
    total++;
    if (branch_taken !== e.bt) begin bad++; $display("FAIL branch_taken op=%0d: got %b want %b", op, branch_taken, e.bt); end
    total++;
    if ({alu_data1, alu_data2, alu_select} !== {e.d1, e.d2, e.sel}) begin
      bad++;
      $display("FAIL operands_held op=%0d: got %h/%h/%0d want %h/%h/%0d", op, alu_data1, alu_data2, alu_select, e.d1, e.d2, e.sel);
    end
    if (e.wr) m[e.rd] = e.val;
    @(negedge clk);
    if (!keep) instr_valid = 0;
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL done_width op=%0d: got %b want 0", op, done); end
    dbg_addr = e.rd;
    #1;
    total++;
    if (dbg_data !== m[e.rd]) begin bad++; $display("FAIL writeback R%0d: got %h want %h", e.rd, dbg_data, m[e.rd]); end
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (instr_ready !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_hold: ready=%b done=%b want 0 0", instr_ready, done); end
    reset = 1;
    #1;
    total++;
    if (instr_ready !== 1'b1) begin bad++; $display("FAIL reset_release: ready=%b want 1", instr_ready); end
    total++;
    if ({alu_data1, alu_data2, alu_select, branch_taken} !== 20'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h/%h/%0d/%b want 0", alu_data1, alu_data2, alu_select, branch_taken);
    end
    for (int i = 0; i < 8; i++) begin
      m[i] = 8'h00;
      dbg_addr = 3'(i);
      #1;
      total++;
      if (dbg_data !== 8'h00) begin bad++; $display("FAIL reset_reg R%0d: got %h want 00", i, dbg_data); end
    end
  endtask

  task automatic test_loadi_add();
    issue(3'd0, 3'd1, 3'd0, 3'd0, 8'h05, 0);
    issue(3'd0, 3'd2, 3'd0, 3'd0, 8'h03, 0);
    issue(3'd2, 3'd3, 3'd1, 3'd2, 8'h00, 0);
    dbg_addr = 3;
    #1;
    total++;
    if (dbg_data !== 8'h08) begin bad++; $display("FAIL add_r3: got %h want 08", dbg_data); end
  endtask

  task automatic test_sub_wrap();
    issue(3'd3, 3'd4, 3'd2, 3'd1, 8'h00, 0);
    issue(3'd0, 3'd5, 3'd0, 3'd0, 8'hFF, 0);
    issue(3'd0, 3'd6, 3'd0, 3'd0, 8'h01, 0);
    issue(3'd2, 3'd7, 3'd5, 3'd6, 8'h00, 0);
    dbg_addr = 4;
    #1;
    total++;
    if (dbg_data !== 8'hFE) begin bad++; $display("FAIL sub_r4: got %h want fe", dbg_data); end
    dbg_addr = 7;
    #1;
    total++;
    if (dbg_data !== 8'h00) begin bad++; $display("FAIL add_wrap_r7: got %h want 00", dbg_data); end
  endtask

  task automatic test_beq();
    issue(3'd6, 3'd0, 3'd1, 3'd1, 8'h00, 0);
    issue(3'd6, 3'd0, 3'd1, 3'd2, 8'h00, 0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      total++;
      if (dbg_data !== m[i]) begin bad++; $display("FAIL beq_noreg R%0d: got %h want %h", i, dbg_data, m[i]); end
    end
  endtask

  task automatic test_abort();
    logic seen;
    seen = 0;
    instr_valid = 1; opcode = 3'd2; rd = 3'd3; rs = 3'd1; rt = 3'd2;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      seen |= done;
      if (k == 1) instr_valid = 0;
      if (k == 2) reset = 0;
      if (k == 3) reset = 1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL abort_done: got %b want 0", seen); end
    for (int i = 0; i < 8; i++) m[i] = 8'h00;
    dbg_addr = 3;
    #1;
    total++;
    if (dbg_data !== 8'h00) begin bad++; $display("FAIL abort_r3: got %h want 00", dbg_data); end
  endtask

  task automatic test_back_to_back();
    issue(3'd0, 3'd1, 3'd0, 3'd0, 8'hF0, 0);
    issue(3'd0, 3'd2, 3'd0, 3'd0, 8'h3C, 0);
    issue(3'd0, 3'd3, 3'd0, 3'd0, 8'h0F, 0);
    acc = 0;
    issue(3'd4, 3'd4, 3'd1, 3'd2, 8'h00, 1);
    issue(3'd5, 3'd5, 3'd1, 3'd3, 8'h00, 1);
    issue(3'd2, 3'd6, 3'd4, 3'd5, 8'h00, 0);
    repeat (3) @(negedge clk);
    total++;
    if (acc !== 3) begin bad++; $display("FAIL b2b_accepts: got %0d want 3", acc); end
    dbg_addr = 4;
    #1;
    total++;
    if (dbg_data !== 8'h30) begin bad++; $display("FAIL and_r4: got %h want 30", dbg_data); end
    dbg_addr = 5;
    #1;
    total++;
    if (dbg_data !== 8'hFF) begin bad++; $display("FAIL or_r5: got %h want ff", dbg_data); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_loadi_add();
    test_sub_wrap();
    test_beq();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
